carry_save_resolver: RTL and testbench
======================================

CARRY_SAVE_RESOLVER -- requirements
Module: carry_save_resolver

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the width of each carry-save input vector.
REQ-002 Parameter CHUNK, default 4, SHALL set the bits resolved per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that sum_in/carry_in hold a carry-save pair.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a pair.
REQ-007 sum_in  input  WIDTH  SHALL carry the per-bit sum vector of a 3:2 compressor stage.
REQ-008 carry_in  input  WIDTH  SHALL carry the per-bit carry vector, bit i weighted 2^(i+1).
REQ-009 out_valid  output  1  SHALL indicate that result holds a resolved value.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts result.
REQ-011 result  output  WIDTH+2  SHALL equal sum_in + (carry_in << 1), exact and unsigned.

Function
REQ-012 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; elsewhere it SHALL be 0.
REQ-014 At an edge with in_valid=1 and in_ready=1: capture sum_in and carry_in<<1 (WIDTH+1 bits); clear the chunk counter and carry register; move to BUSY.
REQ-015 Inputs SHALL be ignored in BUSY and DONE, whatever in_valid does.
REQ-016 In BUSY, chunk k (k = 0..N-1) SHALL be resolved on the k-th edge after capture:
- add bits [k*CHUNK +: CHUNK] of both operands plus the carry register;
- write the chunk sum into result;
- store the chunk carry-out.
REQ-017 On the edge that resolves chunk N-1, the same edge SHALL:
- set result[WIDTH+1:WIDTH] = carry_in[WIDTH-1] + final chunk carry;
- move to DONE.
REQ-018 Latency: out_valid SHALL rise exactly N edges after the accepting edge.
REQ-019 In DONE, out_valid SHALL be 1 and result SHALL hold stable until the out_valid & out_ready edge; that edge SHALL return the FSM to IDLE.
REQ-020 out_ready low SHALL stall DONE indefinitely without corrupting result.
REQ-021 out_valid SHALL be 0 in IDLE and BUSY.
REQ-022 result bits not yet written in BUSY are don't-care.
REQ-023 Minimum initiation interval SHALL be N+2 cycles: no accept on the edge leaving DONE.
REQ-024 The chunk counter SHALL be ceil(log2(N))+1 bits and SHALL NOT wrap inside one operation.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, in_ready=1, out_valid=0, result=0, counter=0, carry register=0, captured operands=0.
REQ-026 Reset asserted in BUSY or DONE SHALL abort the operation with no out_valid pulse.
REQ-027 Accepts SHALL be possible from the first rising edge after rst_n deasserts.

Configuration
REQ-028 With macro CARRY_SAVE_RESOLVER_OVF_EN defined, output overflow (1 bit) SHALL equal |result[WIDTH+1:WIDTH], valid while out_valid=1.
REQ-029 overflow SHALL be 0 at reset and outside DONE.
REQ-030 Without the macro, the overflow port and its logic SHALL NOT exist; all other behaviour is identical.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-031 Scenario 1: sum_in=0x0000, carry_in=0x0000 -> result 0x00000 after 4 edges; overflow 0.
REQ-032 Scenario 2: sum_in=0x1234, carry_in=0x0001 -> result 0x01236; overflow 0.
REQ-033 Scenario 3: sum_in=0xFFFF, carry_in=0xFFFF -> result 0x2FFFD; overflow 1.
REQ-034 Scenario 4: sum_in=0x00FF, carry_in=0x0080, out_ready held 0 for 10 cycles -> result 0x001FF held stable; in_ready 0 throughout; IDLE one edge after out_ready=1.
REQ-035 Scenario 5: rst_n pulsed low 2 edges after accept -> out_valid never rises; result 0; next pair resolves correctly.
REQ-036 Scenario 6: in_valid held 1 with changing data during BUSY -> only the first pair resolves; next accept occurs after the DONE handshake.

Source files
------------

// File: rtl/carry_save_resolver.sv
// Chunk-serial resolver: folds a carry-save pair (sum, carry<<1) into one exact
// binary value, CHUNK bits per cycle. Optional overflow flag: CARRY_SAVE_RESOLVER_OVF_EN.

module csr_chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o
);
  logic [CHUNK:0] full;
  assign full = {1'b0, a_i} + {1'b0, b_i} + (CHUNK+1)'(ci_i);
  assign s_o  = full[CHUNK-1:0];
  assign co_o = full[CHUNK];
endmodule

module carry_save_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
  output logic             overflow,
`endif
  output logic [WIDTH+1:0] result
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH+1:0] res_q, res_d;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_co;

  // Operands shift right each cycle so the active chunk always sits at bit 0.
  csr_chunk_add #(.CHUNK(CHUNK)) u_add (
    .a_i  (a_q[CHUNK-1:0]),
    .b_i  (b_q[CHUNK-1:0]),
    .ci_i (cy_q),
    .s_o  (ch_sum),
    .co_o (ch_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = sum_in;
          b_d     = {carry_in, 1'b0};
          cnt_d   = '0;
          cy_d    = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        cy_d  = ch_co;
        cnt_d = cnt_q + CW'(1);
        // Low result half fills from the top; after N chunks it is aligned.
        res_d[WIDTH-1:0] = (res_q[WIDTH-1:0] >> CHUNK) | (WIDTH'(ch_sum) << (WIDTH - CHUNK));
        if (cnt_q == CW'(N - 1)) begin
          // b_q[CHUNK] is the shifted-down carry_in[WIDTH-1].
          res_d[WIDTH+1:WIDTH] = {1'b0, b_q[CHUNK]} + {1'b0, ch_co};
          cnt_d   = cnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;

`ifdef CARRY_SAVE_RESOLVER_OVF_EN
  assign overflow = (state_q == DONE) & (|res_q[WIDTH+1:WIDTH]);
`endif

endmodule

// File: tb/tb_carry_save_resolver.sv
// Randomized + directed bench for carry_save_resolver against a transaction-level model.
module tb_carry_save_resolver;
  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  sum_in = '0;
  logic [W-1:0]  carry_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W+1:0]  result;
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
  logic          overflow;
`endif

  int checks = 0;
  int errors = 0;

  carry_save_resolver #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
    .overflow  (overflow),
`endif
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted pair becomes visible N edges later and
  // stays until the consumer takes it.
  bit           m_active = 0;
  int           m_age = 0;
  logic [W+1:0] m_exp = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      m_age    = 0;
      chk("reset_result", result, '0);
    end
    chk("in_ready", in_ready, !m_active);
    chk("out_valid", out_valid, m_active && m_age >= N);
    if (m_active && m_age >= N) begin
      chk("result", result, m_exp);
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
      chk("overflow", overflow, m_exp[W+1:W] != 0);
`endif
    end
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
    else chk("overflow_idle", overflow, 1'b0);
`endif
    if (rst_n) begin
      if (!m_active) begin
        if (in_valid) begin
          m_active = 1;
          m_age    = 0;
          m_exp    = (W+2)'(sum_in) + ((W+2)'(carry_in) << 1);
        end
      end else if (m_age >= N) begin
        if (out_ready) m_active = 0;
      end else begin
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair, measure latency, optionally stall, then hand it off.
  task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] c,
                        input logic [W+1:0] lit, input int stall, input string name);
    int lat;
    chk({name, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; sum_in = s; carry_in = c;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, lat, N);
    chk({name, "_literal"}, result, lit);
    repeat (stall) begin
      tick();
      chk({name, "_stall_hold"}, result, lit);
      chk({name, "_stall_inrdy"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    tick(); tick();
    rst_n = 1'b1;

    run_op(16'h0000, 16'h0000, 18'h00000, 0, "s1");
    run_op(16'h1234, 16'h0001, 18'h01236, 0, "s2");
    run_op(16'hFFFF, 16'hFFFF, 18'h2FFFD, 0, "s3");
    run_op(16'h00FF, 16'h0080, 18'h001FF, 10, "s4");

    // Reset in the middle of an operation.
    in_valid = 1'b1; sum_in = 16'hABCD; carry_in = 16'h1111;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("s5_abort_result", result, '0);
    chk("s5_abort_valid", out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("s5_no_valid", out_valid, 1'b0);
    end
    run_op(16'h8001, 16'h4000, 18'h10001, 0, "s5_next");

    // in_valid held high with changing data during the whole operation.
    in_valid = 1'b1; sum_in = 16'h0F0F; carry_in = 16'h00F0;
    tick();
    lat = 0;
    while (!out_valid && lat < 20) begin
      sum_in = W'($urandom); carry_in = W'($urandom);
      tick();
      lat++;
    end
    chk("s6_latency", lat, N);
    chk("s6_first_only", result, 18'h010EF);
    sum_in = 16'h0003; carry_in = 16'h0002;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s6_idle_after_hs", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("s6_next_accepted", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("s6_next_result", result, 18'h00007);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Random traffic, random backpressure, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       begin sum_in = '1; carry_in = '1; end
        1:       begin sum_in = '0; carry_in = W'($urandom); end
        default: begin sum_in = W'($urandom); carry_in = W'($urandom); end
      endcase
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
